controle_varredura: RTL and testbench
=====================================

# controle_varredura

Scan controller for the 5×7 LED dot-matrix display. It generates the 3-bit row index consumed by the combinational frame-pattern blocks (`quadro_0`…`quadro_3`, each mapping `contador[2:0]` to `colunas[4:0]`), and selects which pattern is shown. It registers the selected column pattern and drives the active-low row lines with a one-cycle blanking gap between rows. The displayed frame advances automatically after a programmable dwell, or manually on request.

## Interface
- `DIV`, default 4: clock cycles each row is lit (≥1).
- `HOLD`, default 2: complete scan frames per picture in auto mode (≥1).
- `NUM_QUADROS`, default 4: number of pictures in rotation (1..4).

Ports:
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  1 = scanning; 0 = display dark.
- `modo`  in  1  0 = auto rotation; 1 = manual.
- `proximo`  in  1  manual advance request, level sampled each cycle; ignored when `modo`=0.
- `colunas_q0`…`colunas_q3`  in  5 each  pattern-block outputs for the current `contador`.
- `contador`  out  3  row index 0..6, fed to all pattern blocks.
- `linhas`  out  7  row drive, active low; bit i lights row i.
- `colunas`  out  5  registered column pattern.
- `quadro_atual`  out  2  picture index 0..NUM_QUADROS-1.
- `fim_quadro`  out  1  one-cycle pulse at each frame wrap.

## Operation
- Reset values: `contador`=0, `linhas`=7'h7F, `colunas`=0, `quadro_atual`=0, `fim_quadro`=0, state PARADO, prescaler=0, frame count=0, pending request=0.
- State PARADO: outputs are at reset values, except `quadro_atual`, which is retained. `enable`=1 moves the block to BLANK with `contador`=0.
- State BLANK (1 cycle): `linhas`=7'h7F. At the end of the cycle, `colunas` loads `colunas_q[quadro_atual]`, which is the mux of the four inputs indexed by `quadro_atual`. The block then moves to EXIBE.
- State EXIBE (DIV cycles): `linhas` = ~(1<<`contador`). `colunas` is held.
- At the end of EXIBE:
  - `contador` increments and the block moves to BLANK.
  - If `contador`=6, it wraps to 0 and a frame boundary occurs.
- Frame boundary, applied in the same edge as the wrap:
  - `fim_quadro`=1 for the following BLANK cycle.
  - Frame count increments.
  - Auto mode: when the count reaches HOLD, the count clears and `quadro_atual` advances.
  - Manual mode: if a request is pending, `quadro_atual` advances and the request clears.
- Advance rule: `quadro_atual` goes +1, wrapping NUM_QUADROS-1 → 0. With NUM_QUADROS=1 it stays 0.
- Manual request capture:
  - A rising edge of `proximo` sets the pending request.
  - Multiple edges within one frame still produce a single advance.
  - An edge in the same cycle as the wrap is applied at the next boundary, not the current one.
- Mode change: any change of `modo` clears the frame count and the pending request. `quadro_atual` is unchanged.
- `enable` falling in any state: the next state is PARADO. Prescaler, `contador` and frame count clear, and the row is dark on the next cycle.
- Asynchronous `reset` mid-scan: all outputs take their reset values immediately, regardless of `clock`.

## Timing
- Row period = DIV+1 cycles. Frame period = 7·(DIV+1) cycles; with defaults, 35 cycles.
- Latency from the cycle `enable` is sampled high to first lit row: 2 edges (BLANK, then EXIBE).
- The picture change is visible starting with row 0 of the new frame, because `colunas` is loaded in the BLANK after the wrap using the new `quadro_atual`.
- `linhas` and `colunas` are registered, with no combinational path from inputs. `contador` is registered. Pattern blocks must settle within one cycle.
- A lit row never overlaps another: at least one all-high `linhas` cycle separates them.

## Test plan
- **Reset and idle.** Assert `reset` with `enable`=1 mid-row. Required: same cycle `linhas`=7F, `colunas`=0, `contador`=0. After release with `enable`=0, the outputs stay at those values.
- **Basic scan.** DIV=4; `colunas_q0` = 5'h11 when `contador`=0. Raise `enable`. Required:
  - 1 BLANK cycle, then 4 cycles of `linhas`=7'b1111110 with `colunas`=5'h11.
  - `contador` reaches 6 after 30 cycles.
  - `fim_quadro` pulses once per 35 cycles.
- **Auto rotation.** HOLD=2, NUM_QUADROS=3. Required: `quadro_atual` sequence 0→1→2→0, with changes every 70 cycles, coincident with `fim_quadro`.
- **Manual advance.** `modo`=1; pulse `proximo` three times within one frame. Required: exactly one increment, at the next wrap. A pulse in the wrap cycle takes effect one frame later.
- **Mid-frame disable.** Drop `enable` during row 3 EXIBE. Required: next cycle `linhas`=7F, `contador`=0. Re-enable restarts at row 0 with the same `quadro_atual`.
- **Mode toggle.** Auto, 1 frame elapsed, switch to manual and back. Required: dwell restarts, so the next advance comes 2 full frames later.

Source files
------------

// File: rtl/controle_varredura.sv
// Row-scan controller for the 5x7 LED dot matrix: row timing with a blanking gap,
// registered column pattern and picture rotation (automatic dwell or manual request).
//
// state  | meaning
// PARADO | display dark, waiting for enable
// BLANK  | one dark cycle between rows; column pattern loads at its end
// EXIBE  | row `contador` lit for DIV cycles
module controle_varredura #(
    parameter int DIV         = 4,
    parameter int HOLD        = 2,
    parameter int NUM_QUADROS = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       modo,
    input  logic       proximo,
    input  logic [4:0] colunas_q0,
    input  logic [4:0] colunas_q1,
    input  logic [4:0] colunas_q2,
    input  logic [4:0] colunas_q3,
    output logic [2:0] contador,
    output logic [6:0] linhas,
    output logic [4:0] colunas,
    output logic [1:0] quadro_atual,
    output logic       fim_quadro
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int FW = (HOLD > 1) ? $clog2(HOLD + 1) : 1;
    localparam logic [PW-1:0] PRE_CARGA = PW'(DIV - 1);
    localparam logic [FW-1:0] HOLD_FIM  = FW'(HOLD - 1);
    localparam logic [1:0]    ULTIMO    = 2'(NUM_QUADROS - 1);

    typedef enum logic [1:0] {PARADO, BLANK, EXIBE} estado_t;

    estado_t       estado, estado_next;
    logic [PW-1:0] prescaler, prescaler_next;
    logic [FW-1:0] contagem, contagem_next;
    logic          pendente, pendente_next;
    logic          proximo_d, modo_d;
    logic [2:0]    contador_next;
    logic [6:0]    linhas_next;
    logic [4:0]    colunas_next, padrao;
    logic [1:0]    quadro_next;
    logic          fim_next, wrap, avanca;

    always_comb begin
        case (quadro_atual)
            2'd0:    padrao = colunas_q0;
            2'd1:    padrao = colunas_q1;
            2'd2:    padrao = colunas_q2;
            default: padrao = colunas_q3;
        endcase
    end

    always_comb begin
        estado_next    = estado;
        prescaler_next = prescaler;
        contador_next  = contador;
        linhas_next    = 7'h7F;
        colunas_next   = colunas;
        quadro_next    = quadro_atual;
        fim_next       = 1'b0;
        contagem_next  = contagem;
        pendente_next  = pendente;
        wrap           = 1'b0;
        avanca         = 1'b0;

        if (!enable) begin
            estado_next    = PARADO;
            prescaler_next = '0;
            contador_next  = 3'd0;
            colunas_next   = 5'd0;
            contagem_next  = '0;
        end else begin
            case (estado)
                PARADO: begin
                    estado_next   = BLANK;
                    contador_next = 3'd0;
                end
                BLANK: begin
                    estado_next    = EXIBE;
                    colunas_next   = padrao;
                    prescaler_next = PRE_CARGA;
                    linhas_next    = ~(7'b1 << contador);
                end
                EXIBE: begin
                    if (prescaler == '0) begin
                        estado_next = BLANK;
                        if (contador == 3'd6) begin
                            contador_next = 3'd0;
                            wrap          = 1'b1;
                            fim_next      = 1'b1;
                        end else begin
                            contador_next = contador + 3'd1;
                        end
                    end else begin
                        prescaler_next = prescaler - 1'b1;
                        linhas_next    = ~(7'b1 << contador);
                    end
                end
                default: estado_next = PARADO;
            endcase
        end

        if (wrap) begin
            if (!modo) begin
                if (contagem == HOLD_FIM) begin
                    contagem_next = '0;
                    avanca        = 1'b1;
                end else begin
                    contagem_next = contagem + 1'b1;
                end
            end else if (pendente) begin
                pendente_next = 1'b0;
                avanca        = 1'b1;
            end
        end

        // a request edge arriving on the wrap itself survives the clear above
        if (modo && proximo && !proximo_d) pendente_next = 1'b1;

        if (modo != modo_d) begin
            contagem_next = '0;
            pendente_next = 1'b0;
            avanca        = 1'b0;
        end

        if (avanca) quadro_next = (quadro_atual == ULTIMO) ? 2'd0 : quadro_atual + 2'd1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado       <= PARADO;
            prescaler    <= '0;
            contador     <= 3'd0;
            linhas       <= 7'h7F;
            colunas      <= 5'd0;
            quadro_atual <= 2'd0;
            fim_quadro   <= 1'b0;
            contagem     <= '0;
            pendente     <= 1'b0;
            proximo_d    <= 1'b0;
            modo_d       <= 1'b0;
        end else begin
            estado       <= estado_next;
            prescaler    <= prescaler_next;
            contador     <= contador_next;
            linhas       <= linhas_next;
            colunas      <= colunas_next;
            quadro_atual <= quadro_next;
            fim_quadro   <= fim_next;
            contagem     <= contagem_next;
            pendente     <= pendente_next;
            proximo_d    <= proximo;
            modo_d       <= modo;
        end
    end
endmodule

// File: tb/tb_controle_varredura.sv
// Bench for controle_varredura: vector table, hand-written corner sequences and
// randomized stimulus against a time-index reference model of the scan.
module tb_controle_varredura;
    localparam int DIV   = 4;
    localparam int HOLD  = 2;
    localparam int NQ    = 3;
    localparam int LINHA = DIV + 1;
    localparam int FRAME = 7 * LINHA;

    logic       clock, reset, enable, modo, proximo;
    logic [4:0] colunas_q0, colunas_q1, colunas_q2, colunas_q3;
    logic [2:0] contador;
    logic [6:0] linhas;
    logic [4:0] colunas;
    logic [1:0] quadro_atual;
    logic       fim_quadro;

    int total = 0;
    int bad   = 0;

    function automatic logic [4:0] pat(input int n, input logic [2:0] r);
        logic [4:0] v;
        v = {n[1:0], r};
        return v ^ 5'h11;
    endfunction

    assign colunas_q0 = pat(0, contador);
    assign colunas_q1 = pat(1, contador);
    assign colunas_q2 = pat(2, contador);
    assign colunas_q3 = pat(3, contador);

    controle_varredura #(.DIV(DIV), .HOLD(HOLD), .NUM_QUADROS(NQ)) dut (
        .clock(clock), .reset(reset), .enable(enable), .modo(modo), .proximo(proximo),
        .colunas_q0(colunas_q0), .colunas_q1(colunas_q1),
        .colunas_q2(colunas_q2), .colunas_q3(colunas_q3),
        .contador(contador), .linhas(linhas), .colunas(colunas),
        .quadro_atual(quadro_atual), .fim_quadro(fim_quadro)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: scan position is a plain time index k counted from the first BLANK.
    bit         m_on, m_fim, m_pend, m_px_prev, m_md_prev;
    int         m_k, m_frames;
    logic [1:0] m_q;
    logic [4:0] m_col;

    task automatic model_reset();
        m_on = 0; m_fim = 0; m_pend = 0; m_px_prev = 0; m_md_prev = 0;
        m_k = 0; m_frames = 0; m_q = 2'd0; m_col = 5'd0;
    endtask

    task automatic model_edge(input logic en, input logic md, input logic px);
        bit wrap, adv;
        wrap = 0;
        adv  = 0;
        if (!en) begin
            m_on = 0; m_k = 0; m_col = 5'd0; m_frames = 0;
        end else if (!m_on) begin
            m_on = 1; m_k = 0;
        end else begin
            m_k++;
            if (m_k % LINHA == 1) m_col = pat(int'(m_q), 3'((m_k / LINHA) % 7));
            wrap = (m_k % FRAME == 0);
        end
        if (wrap) begin
            if (!md) begin
                m_frames++;
                if (m_frames == HOLD) begin m_frames = 0; adv = 1; end
            end else if (m_pend) begin
                m_pend = 0; adv = 1;
            end
        end
        if (md && px && !m_px_prev) m_pend = 1;
        if (md != m_md_prev) begin m_frames = 0; m_pend = 0; adv = 0; end
        if (adv) m_q = 2'((int'(m_q) + 1) % NQ);
        m_fim = wrap; m_px_prev = px; m_md_prev = md;
    endtask

    function automatic logic [17:0] esperado();
        logic [2:0] r;
        logic [6:0] l;
        if (!m_on) return {3'd0, 7'h7F, 5'd0, m_q, 1'b0};
        r = 3'((m_k / LINHA) % 7);
        l = (m_k % LINHA == 0) ? 7'h7F : ~(7'd1 << r);
        return {r, l, m_col, m_q, m_fim};
    endfunction

    function automatic logic [17:0] saida();
        return {contador, linhas, colunas, quadro_atual, fim_quadro};
    endfunction

    task automatic check(input string nome, input logic [31:0] obtido, input logic [31:0] exp_v);
        total++;
        if (obtido !== exp_v) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nome, obtido, exp_v, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        if (reset) model_reset();
        else model_edge(enable, modo, proximo);
        #1;
    endtask

    task automatic ate_k(input int alvo);
        int n;
        n = 0;
        while (!(m_on && m_k == alvo) && n < 1000) begin
            step();
            n++;
        end
        if (n >= 1000) begin
            total++;
            bad++;
            $display("FAIL ate_k: scan position %0d not reached, at %0d", alvo, m_k);
        end
    endtask

    typedef struct {
        logic       en, md, px;
        int         n;
        logic [2:0] cont;
        logic [6:0] lin;
        logic [4:0] col;
        logic       fim;
        logic [1:0] q;
    } vetor_t;

    vetor_t tab[$];

    task automatic add(input logic en, input logic md, input logic px, input int n,
                       input logic [2:0] cont, input logic [6:0] lin, input logic [4:0] col,
                       input logic fim, input logic [1:0] q);
        vetor_t v;
        v.en = en; v.md = md; v.px = px; v.n = n;
        v.cont = cont; v.lin = lin; v.col = col; v.fim = fim; v.q = q;
        tab.push_back(v);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; enable = 1'b0; modo = 1'b0; proximo = 1'b0;
        model_reset();

        //  en md px  n   cont  linhas  col    fim q
        add(0, 0, 0, 3,  3'd0, 7'h7F, 5'h00, 0, 2'd0);
        add(1, 0, 0, 1,  3'd0, 7'h7F, 5'h00, 0, 2'd0);
        add(1, 0, 0, 1,  3'd0, 7'h7E, 5'h11, 0, 2'd0);
        add(1, 0, 0, 3,  3'd0, 7'h7E, 5'h11, 0, 2'd0);
        add(1, 0, 0, 1,  3'd1, 7'h7F, 5'h11, 0, 2'd0);
        add(1, 0, 0, 1,  3'd1, 7'h7D, 5'h10, 0, 2'd0);
        add(1, 0, 0, 24, 3'd6, 7'h7F, 5'h14, 0, 2'd0);
        add(1, 0, 0, 1,  3'd6, 7'h3F, 5'h17, 0, 2'd0);
        add(1, 0, 0, 4,  3'd0, 7'h7F, 5'h17, 1, 2'd0);
        add(1, 0, 0, 1,  3'd0, 7'h7E, 5'h11, 0, 2'd0);
        add(1, 0, 0, 34, 3'd0, 7'h7F, 5'h17, 1, 2'd1);
        add(1, 0, 0, 1,  3'd0, 7'h7E, 5'h19, 0, 2'd1);
        add(1, 0, 0, 10, 3'd2, 7'h7B, 5'h1B, 0, 2'd1);
        add(1, 0, 0, 5,  3'd3, 7'h77, 5'h1A, 0, 2'd1);
        add(0, 0, 0, 1,  3'd0, 7'h7F, 5'h00, 0, 2'd1);
        add(0, 0, 0, 2,  3'd0, 7'h7F, 5'h00, 0, 2'd1);
        add(1, 0, 0, 1,  3'd0, 7'h7F, 5'h00, 0, 2'd1);
        add(1, 0, 0, 1,  3'd0, 7'h7E, 5'h19, 0, 2'd1);
        add(1, 0, 0, 69, 3'd0, 7'h7F, 5'h1F, 1, 2'd2);
        add(1, 0, 0, 1,  3'd0, 7'h7E, 5'h01, 0, 2'd2);
        add(1, 0, 0, 69, 3'd0, 7'h7F, 5'h07, 1, 2'd0);
        add(1, 0, 0, 1,  3'd0, 7'h7E, 5'h11, 0, 2'd0);

        step();
        check("rst_linhas", 32'(linhas), 32'h7F);
        check("rst_colunas", 32'(colunas), 32'h0);
        check("rst_contador", 32'(contador), 32'h0);
        check("rst_quadro", 32'(quadro_atual), 32'h0);
        check("rst_fim", 32'(fim_quadro), 32'h0);
        reset = 1'b0;

        foreach (tab[i]) begin
            enable = tab[i].en; modo = tab[i].md; proximo = tab[i].px;
            repeat (tab[i].n) step();
            check($sformatf("tab%0d", i), 32'(saida()),
                  32'({tab[i].cont, tab[i].lin, tab[i].col, tab[i].q, tab[i].fim}));
            check($sformatf("tab%0d_model", i), 32'(saida()), 32'(esperado()));
        end

        // asynchronous reset in the middle of a lit row, checked before any clock edge
        #2 reset = 1'b1;
        #1;
        check("async_linhas", 32'(linhas), 32'h7F);
        check("async_colunas", 32'(colunas), 32'h0);
        check("async_contador", 32'(contador), 32'h0);
        check("async_quadro", 32'(quadro_atual), 32'h0);
        step();
        enable = 1'b0;
        reset  = 1'b0;
        repeat (3) step();
        check("idle_after_reset", 32'(saida()), 32'({3'd0, 7'h7F, 5'd0, 2'd0, 1'b0}));

        // manual: three requests in one frame give a single advance at the next wrap
        modo = 1'b1;
        step();
        enable = 1'b1;
        ate_k(8);
        for (int i = 0; i < 3; i++) begin
            proximo = 1'b1; step();
            proximo = 1'b0; step(); step();
        end
        ate_k(34);
        check("man_before_wrap", 32'(quadro_atual), 32'd0);
        ate_k(35);
        check("man_adv_q", 32'(quadro_atual), 32'd1);
        check("man_adv_fim", 32'(fim_quadro), 32'd1);
        ate_k(70);
        check("man_single_adv", 32'(quadro_atual), 32'd1);
        // request sampled on the wrap edge waits one more frame
        ate_k(104);
        proximo = 1'b1;
        step();
        check("man_wrap_req_q", 32'(quadro_atual), 32'd1);
        check("man_wrap_req_fim", 32'(fim_quadro), 32'd1);
        proximo = 1'b0;
        ate_k(140);
        check("man_late_adv", 32'(quadro_atual), 32'd2);
        check("man_model", 32'(saida()), 32'(esperado()));

        // auto dwell restarts after a manual detour
        enable = 1'b0;
        modo   = 1'b0;
        step(); step();
        enable = 1'b1;
        ate_k(35);
        check("tog_first_frame", 32'(quadro_atual), 32'd2);
        ate_k(40);
        modo = 1'b1;
        ate_k(45);
        modo = 1'b0;
        ate_k(70);
        check("tog_no_adv_q", 32'(quadro_atual), 32'd2);
        check("tog_no_adv_fim", 32'(fim_quadro), 32'd1);
        ate_k(105);
        check("tog_adv", 32'(quadro_atual), 32'd0);
        check("tog_model", 32'(saida()), 32'(esperado()));

        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 999) < 2) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
            end
            enable  = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 199) == 0) modo = ~modo;
            proximo = ($urandom_range(0, 7) == 0);
            step();
            check("aleatorio", 32'(saida()), 32'(esperado()));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
